fft_input_loader: RTL and testbench
===================================

// Module: fft_input_loader
// PURPOSE
//  Upstream feeder for the 32-point radix-2 FFT butterfly array. Collects a serial
//  stream of complex samples (valid/ready) into one frame buffer in bit-reversed
//  order, then presents the whole frame in parallel to the first butterfly stage.
//  The frame is handed over through a frame_valid/frame_ready handshake.
// PARAMETERS
//  N      32  points per frame (power of 2)
//  LOG2N  5   log2(N); width of fill_cnt and bit-reverse index
//  DW     32  bits per real or imaginary component
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       asynchronous active-low reset
//  in_valid     in   1       input sample valid
//  in_ready     out  1       loader can accept a sample
//  in_r         in   DW      sample real part
//  in_i         in   DW      sample imaginary part
//  in_last      in   1       marks last sample of a frame (early-last check)
//  frame_valid  out  1       full frame available on frame_r/frame_i
//  frame_ready  in   1       butterfly array takes the frame
//  frame_r      out  N*DW    slot s real part at [s*DW +: DW]
//  frame_i      out  N*DW    slot s imaginary part at [s*DW +: DW]
//  frame_err    out  1       1-cycle pulse: in_last accepted before sample N-1
//  fill_cnt     out  LOG2N   samples accepted into the current frame
// BEHAVIOUR
//  - Reset (rst=0, async): frame_valid=0, frame_err=0, fill_cnt=0, frame_r/frame_i=0.
//    in_ready=0 while rst=0. State enters FILL. in_ready=1 on the first clk after release.
//  - Accept happens when in_valid & in_ready at a rising edge.
//  - Sample with arrival index k (0..N-1) is written to slot bitrev_LOG2N(k). fill_cnt increments.
//  - FSM states are FILL and FULL.
//    - FILL: in_ready=1.
//    - The accept at fill_cnt=N-1 wraps fill_cnt to 0 and moves the FSM to FULL.
//      frame_valid rises on the next cycle, so latency is 1 clk after the N-th accept.
//    - FULL: in_ready=0. frame_valid=1. frame_r/frame_i stay stable.
//    - frame_valid & frame_ready at an edge moves the FSM to FILL.
//      frame_valid=0 and in_ready=1 from the next cycle.
//      A sample offered in the handshake cycle is not accepted.
//  - in_last accepted with fill_cnt != N-1:
//    - frame_err pulses for 1 cycle and fill_cnt is cleared to 0.
//    - The partial frame is discarded. No frame_valid is raised.
//    - The stale slot contents are never exposed with frame_valid=1.
//  - in_last=0 on the accept at fill_cnt=N-1 is not an error; the frame completes on count alone.
//  - in_valid while in_ready=0 is ignored. There is no overflow and no data loss.
//  - Arithmetic: no arithmetic is done on data. Samples are stored bit-exact (DW two's complement).
//  - Reset mid-fill or while FULL: returns to the reset values. Partial and pending frames are dropped.
// CONFIGURATION
//  - LOADER_PINGPONG_EN defined: two banks A and B.
//    - Write bank and read bank alternate. frame_r/frame_i always drive the read bank.
//    - in_ready=0 only while both banks are full and waiting.
//    - Otherwise filling continues while a frame is held, so back-to-back frames run at 1 sample/clk.
//    - Frames are delivered in fill order.
//    - A frame handshake and a bank completion in the same cycle are both honoured.
//      The completed bank becomes the read bank, and frame_valid stays 1 with no gap.
//  - LOADER_PINGPONG_EN undefined: single bank, FILL/FULL behaviour as above.
//    in_ready=0 for the whole time the frame is held.
// TESTING
//  1. Hold rst=0 -> all outputs 0 and in_ready=0.
//     Release rst -> in_ready=1 on the next clk.
//  2. Send 32 samples in_r=k, in_i=-k with frame_ready=1:
//     - frame_valid pulses 1 clk after the 32nd accept.
//     - frame_r slot 1 = 16, slot 16 = 1, slot 31 = 31, slot 0 = 0; frame_i holds the negated values.
//  3. Hold frame_ready=0 for 10 clks after the frame completes -> frame_valid=1 and frame_r stable.
//     in_ready=0 without pingpong, 1 with pingpong.
//     Raise frame_ready -> frame_valid drops the next clk.
//  4. Set in_last=1 on k=9 -> frame_err=1 for exactly 1 clk, fill_cnt=0, no frame_valid.
//     The next 32 samples produce a correct frame.
//  5. Assert rst at fill_cnt=17 -> fill_cnt=0 immediately. No frame_valid after release.
//  6. With LOADER_PINGPONG_EN, stream 96 samples in_valid=1 with frame_ready=0:
//     - in_ready drops after the 64th accept.
//     - Pulsing frame_ready twice delivers frame 0 then frame 1 intact; samples 64..95 then fill.

Source files
------------

// File: rtl/fft_input_loader_if.sv
// rtl/fft_input_loader_if.sv - Sample stream and frame handoff bundle for fft_input_loader
interface fft_input_loader_if #(
    parameter int N     = 32,
    parameter int LOG2N = 5,
    parameter int DW    = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_r;
    logic [DW-1:0]     in_i;
    logic              in_last;
    logic              frame_valid;
    logic              frame_ready;
    logic [N*DW-1:0]   frame_r;
    logic [N*DW-1:0]   frame_i;
    logic              frame_err;
    logic [LOG2N-1:0]  fill_cnt;

    modport master (
        output in_valid, in_r, in_i, in_last, frame_ready,
        input  in_ready, frame_valid, frame_r, frame_i, frame_err, fill_cnt
    );

    modport slave (
        input  in_valid, in_r, in_i, in_last, frame_ready,
        output in_ready, frame_valid, frame_r, frame_i, frame_err, fill_cnt
    );
endinterface

// File: rtl/fft_input_loader.sv
// rtl/fft_input_loader.sv - Serial-to-parallel bit-reversed frame loader for the FFT; LOADER_PINGPONG_EN enables two banks
module fft_input_loader #(
    parameter int N     = 32,
    parameter int LOG2N = 5,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              rst,
    fft_input_loader_if.slave bus
);
    logic [LOG2N-1:0] cnt;
    logic             in_ready_q;
    logic             frame_valid_q;
    logic             frame_err_q;
    logic             accept;
    logic             last_slot;
    logic             early_last;
    logic             complete;
    logic [LOG2N-1:0] wr_slot;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) r[b] = k[LOG2N-1-b];
        return r;
    endfunction

    assign accept     = bus.in_valid & in_ready_q;
    assign last_slot  = (cnt == LOG2N'(N-1));
    assign early_last = accept & bus.in_last & ~last_slot;
    assign complete   = accept & last_slot;
    assign wr_slot    = bitrev(cnt);

    assign bus.in_ready    = in_ready_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.fill_cnt    = cnt;

    // An early in_last restarts the count, so the partial slots are simply overwritten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= early_last;
            if (early_last || complete) cnt <= '0;
            else if (accept)            cnt <= cnt + 1'b1;
        end
    end

`ifdef LOADER_PINGPONG_EN
    logic [N*DW-1:0] bank_r [2];
    logic [N*DW-1:0] bank_i [2];
    logic            wr_bank;
    logic            rd_bank;
    logic [1:0]      bank_full;
    logic [1:0]      full_nxt;
    logic            take;

    assign take        = frame_valid_q & bus.frame_ready;
    assign bus.frame_r = bank_r[rd_bank];
    assign bus.frame_i = bank_i[rd_bank];

    // Release before set so a same-cycle handshake and completion both land.
    always_comb begin
        full_nxt = bank_full;
        if (take)     full_nxt[rd_bank] = 1'b0;
        if (complete) full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            bank_full     <= 2'b00;
            in_ready_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                bank_r[b] <= '0;
                bank_i[b] <= '0;
            end
        end else begin
            if (accept) begin
                bank_r[wr_bank][wr_slot*DW +: DW] <= bus.in_r;
                bank_i[wr_bank][wr_slot*DW +: DW] <= bus.in_i;
            end
            wr_bank       <= wr_bank ^ complete;
            rd_bank       <= rd_bank ^ take;
            bank_full     <= full_nxt;
            frame_valid_q <= |full_nxt;
            in_ready_q    <= ~&full_nxt;
        end
    end
`else
    typedef enum logic {FILL, FULL} state_t;
    state_t          state;
    logic [N*DW-1:0] buf_r;
    logic [N*DW-1:0] buf_i;

    assign bus.frame_r = buf_r;
    assign bus.frame_i = buf_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= FILL;
            in_ready_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            buf_r         <= '0;
            buf_i         <= '0;
        end else begin
            if (accept) begin
                buf_r[wr_slot*DW +: DW] <= bus.in_r;
                buf_i[wr_slot*DW +: DW] <= bus.in_i;
            end
            case (state)
                FILL: begin
                    if (complete) begin
                        state         <= FULL;
                        in_ready_q    <= 1'b0;
                        frame_valid_q <= 1'b1;
                    end else begin
                        in_ready_q    <= 1'b1;
                    end
                end
                FULL: begin
                    if (frame_valid_q && bus.frame_ready) begin
                        state         <= FILL;
                        in_ready_q    <= 1'b1;
                        frame_valid_q <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_fft_input_loader.sv
// tb/tb_fft_input_loader.sv - Directed-random bench for fft_input_loader with a frame-level reference model
`timescale 1ns/1ps
module tb_fft_input_loader;
    localparam int N     = 32;
    localparam int LOG2N = 5;
    localparam int DW    = 32;
`ifdef LOADER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fft_input_loader_if #(.N(N), .LOG2N(LOG2N), .DW(DW)) bus ();
    fft_input_loader #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    logic [N*DW-1:0] exp_r_q[$];
    logic [N*DW-1:0] exp_i_q[$];
    logic [DW-1:0]   cur_r[$];
    logic [DW-1:0]   cur_i[$];

    function automatic int rev(input int k);
        int r = 0;
        int x = k;
        for (int b = 0; b < LOG2N; b++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [DW-1:0] r, input logic [DW-1:0] i, input logic last);
        logic [N*DW-1:0] fr, fi;
        cur_r.push_back(r);
        cur_i.push_back(i);
        if (cur_r.size() == N) begin
            for (int s = 0; s < N; s++) begin
                fr[s*DW +: DW] = cur_r[rev(s)];
                fi[s*DW +: DW] = cur_i[rev(s)];
            end
            exp_r_q.push_back(fr);
            exp_i_q.push_back(fi);
            cur_r.delete();
            cur_i.delete();
        end else if (last) begin
            cur_r.delete();
            cur_i.delete();
        end
    endtask

    task automatic push(input logic [DW-1:0] r, input logic [DW-1:0] i, input logic last);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_r     = r;
        bus.in_i     = i;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 500) begin
            check("ready_timeout", DW'(bus.in_ready), 1);
        end else begin
            @(posedge clk); #1;
            model_accept(r, i, last);
        end
        bus.in_last = 1'b0;
    endtask

    task automatic push_random(input int count);
        for (int k = 0; k < count; k++) push($urandom, $urandom, 1'b0);
    endtask

    task automatic check_head(input string tag);
        if (exp_r_q.size() == 0) begin
            check({tag, "_no_expected_frame"}, DW'(bus.frame_valid), 0);
        end else begin
            for (int s = 0; s < N; s++) begin
                check($sformatf("%s_r_slot%0d", tag, s), bus.frame_r[s*DW +: DW], exp_r_q[0][s*DW +: DW]);
                check($sformatf("%s_i_slot%0d", tag, s), bus.frame_i[s*DW +: DW], exp_i_q[0][s*DW +: DW]);
            end
        end
    endtask

    task automatic pop_expected();
        if (exp_r_q.size() > 0) begin
            void'(exp_r_q.pop_front());
            void'(exp_i_q.pop_front());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic seen_valid;
        logic [DW-1:0] held;
        bus.in_valid    = 1'b0;
        bus.in_r        = '0;
        bus.in_i        = '0;
        bus.in_last     = 1'b0;
        bus.frame_ready = 1'b0;

        // 1: reset values, then in_ready one clock after release
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", DW'(bus.in_ready), 0);
        check("rst_frame_valid", DW'(bus.frame_valid), 0);
        check("rst_frame_err", DW'(bus.frame_err), 0);
        check("rst_fill_cnt", DW'(bus.fill_cnt), 0);
        check("rst_frame_r_or", DW'(|bus.frame_r), 0);
        check("rst_frame_i_or", DW'(|bus.frame_i), 0);
        rst = 1'b1;
        check("rel_in_ready_same_cycle", DW'(bus.in_ready), 0);
        @(posedge clk); #1;
        check("rel_in_ready_next_clk", DW'(bus.in_ready), 1);

        // 2: ramp frame with frame_ready held high
        bus.frame_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            push(DW'(k), DW'(-k), 1'b0);
            if (k == N - 2) check("ramp_valid_before_last", DW'(bus.frame_valid), 0);
            if (k == 4) check("ramp_fill_cnt5", DW'(bus.fill_cnt), 5);
        end
        bus.in_valid = 1'b0;
        check("ramp_valid_after_last", DW'(bus.frame_valid), 1);
        check("ramp_fill_cnt_wrap", DW'(bus.fill_cnt), 0);
        check("ramp_slot1", bus.frame_r[1*DW +: DW], 16);
        check("ramp_slot16", bus.frame_r[16*DW +: DW], 1);
        check("ramp_slot31", bus.frame_r[31*DW +: DW], 31);
        check("ramp_slot0", bus.frame_r[0 +: DW], 0);
        check("ramp_slot1_imag", bus.frame_i[1*DW +: DW], 32'hFFFF_FFF0);
        check_head("ramp");
        @(posedge clk); #1;
        pop_expected();
        check("ramp_valid_pulse_end", DW'(bus.frame_valid), 0);
        bus.frame_ready = 1'b0;

        // 3: held frame stays stable while frame_ready is low
        push_random(N);
        bus.in_valid = 1'b0;
        check("hold_valid", DW'(bus.frame_valid), 1);
        check_head("hold_start");
        held = bus.frame_r[7*DW +: DW];
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold_valid_c%0d", c), DW'(bus.frame_valid), 1);
            check($sformatf("hold_in_ready_c%0d", c), DW'(bus.in_ready), DW'(PP));
            check($sformatf("hold_slot7_c%0d", c), bus.frame_r[7*DW +: DW], exp_r_q[0][7*DW +: DW]);
        end
        check("hold_slot7_unchanged", bus.frame_r[7*DW +: DW], held);
        bus.frame_ready = 1'b1;
        @(posedge clk); #1;
        bus.frame_ready = 1'b0;
        pop_expected();
        check("hold_valid_drop", DW'(bus.frame_valid), 0);
        check("hold_in_ready_back", DW'(bus.in_ready), 1);

        // 4: early in_last on k=9 discards the partial frame
        push_random(9);
        push($urandom, $urandom, 1'b1);
        bus.in_valid = 1'b0;
        check("err_pulse", DW'(bus.frame_err), 1);
        check("err_fill_cnt", DW'(bus.fill_cnt), 0);
        check("err_no_valid", DW'(bus.frame_valid), 0);
        @(posedge clk); #1;
        check("err_pulse_end", DW'(bus.frame_err), 0);
        seen_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | bus.frame_valid;
        end
        check("err_no_valid_later", DW'(seen_valid), 0);
        push_random(N - 1);
        push($urandom, $urandom, 1'b1);
        bus.in_valid = 1'b0;
        check("recover_no_err", DW'(bus.frame_err), 0);
        check("recover_valid", DW'(bus.frame_valid), 1);
        check_head("recover");
        bus.frame_ready = 1'b1;
        @(posedge clk); #1;
        bus.frame_ready = 1'b0;
        pop_expected();
        check("recover_valid_drop", DW'(bus.frame_valid), 0);

        // 5: reset mid-fill
        push_random(17);
        bus.in_valid = 1'b0;
        check("midrst_fill_cnt17", DW'(bus.fill_cnt), 17);
        #2;
        rst = 1'b0;
        #1;
        cur_r.delete();
        cur_i.delete();
        exp_r_q.delete();
        exp_i_q.delete();
        check("midrst_fill_cnt0", DW'(bus.fill_cnt), 0);
        check("midrst_in_ready", DW'(bus.in_ready), 0);
        check("midrst_frame_valid", DW'(bus.frame_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | bus.frame_valid;
        end
        check("midrst_no_valid", DW'(seen_valid), 0);

`ifdef LOADER_PINGPONG_EN
        // 6: two banks fill back to back, then drain in order
        push_random(2 * N);
        check("pp_in_ready_drop", DW'(bus.in_ready), 0);
        check("pp_valid_frame0", DW'(bus.frame_valid), 1);
        check_head("pp_frame0");
        held = $urandom;
        bus.in_valid    = 1'b1;
        bus.in_r        = held;
        bus.in_i        = ~held;
        bus.frame_ready = 1'b1;
        @(posedge clk); #1;
        bus.frame_ready = 1'b0;
        pop_expected();
        check("pp_handshake_no_accept", DW'(bus.fill_cnt), 0);
        check("pp_valid_frame1", DW'(bus.frame_valid), 1);
        check("pp_in_ready_back", DW'(bus.in_ready), 1);
        check_head("pp_frame1");
        push(held, ~held, 1'b0);
        push_random(N - 2);
        bus.frame_ready = 1'b1;
        push($urandom, $urandom, 1'b0);
        bus.frame_ready = 1'b0;
        bus.in_valid    = 1'b0;
        pop_expected();
        check("pp_same_cycle_valid", DW'(bus.frame_valid), 1);
        check_head("pp_frame2");
        bus.frame_ready = 1'b1;
        @(posedge clk); #1;
        bus.frame_ready = 1'b0;
        pop_expected();
        check("pp_drained", DW'(bus.frame_valid), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
